// File: rtl/mux_pkg.sv
// Shared constants and helpers for the parametrised selector family.
package mux_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned REG_W     = 5;

   typedef logic [REG_W-1:0] reg_idx_t;

   // Select width needed to address n inputs (0 for n <= 1).
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (n > (32'd1 << i)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N-way WIDTH-bit selector; out-of-range selects fall back to input 0.
module mux_n_sel
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned SEL_W  = 2
) (
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        out_data,
   output logic                    oob
);

   always_comb begin
      out_data = in_data[WIDTH-1:0];
      oob      = 1'b1;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (sel == k[SEL_W-1:0]) begin
            out_data = in_data[k*WIDTH +: WIDTH];
            oob      = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_n_pipe_reg.sv
// Registered N-way selector stage with valid, stall/flush, sticky select error
// and a saturating capture counter.
module mux_n_pipe_reg
   import mux_pkg::*;
#(
   parameter int unsigned     WIDTH     = DEF_WIDTH,
   parameter int unsigned     NUM_IN    = 4,
   parameter int unsigned     SEL_W     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned     CNT_W     = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   input  logic                    en,
   input  logic                    flush,
   input  logic                    err_clr,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    sel_err,
   output logic [CNT_W-1:0]        cap_cnt
);

   logic [WIDTH-1:0] sel_data;
   logic             sel_oob;
   logic             cap_valid;

   mux_n_sel #(
      .WIDTH (WIDTH),
      .NUM_IN(NUM_IN),
      .SEL_W (SEL_W)
   ) u_sel (
      .in_data (in_data),
      .sel     (sel),
      .out_data(sel_data),
      .oob     (sel_oob)
   );

   // Flush outranks en, so a flushed cycle is never a capture.
   assign cap_valid = en && !flush && in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= RESET_VAL;
         out_valid <= 1'b0;
         out_sel   <= '0;
      end else if (flush) begin
         out_data  <= RESET_VAL;
         out_valid <= 1'b0;
         out_sel   <= '0;
      end else if (en) begin
         out_data  <= sel_data;
         out_valid <= in_valid;
         out_sel   <= sel_oob ? '0 : sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err <= 1'b0;
      end else if (cap_valid && sel_oob) begin
         sel_err <= 1'b1;
      end else if (err_clr) begin
         sel_err <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_cnt <= '0;
      end else if (cap_valid && (cap_cnt != '1)) begin
         cap_cnt <= cap_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mux_n_pipe_reg.sv
// Bench for mux_n_pipe_reg: three configurations driven in parallel against a
// behavioural model, plus literal checks for the directed scenarios.
module tb_mux_n_pipe_reg;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [127:0] din;
   logic [1:0]   sel;
   logic         in_valid, en, flush, err_clr;
   logic         run_chk = 1'b0;

   // a: NUM_IN=3 (oob reachable), CNT_W=4; c: defaults; b: 5-bit, 2 inputs
   logic [31:0] a_data, c_data;
   logic [4:0]  b_data;
   logic        a_valid, c_valid, b_valid;
   logic [1:0]  a_sel, c_sel;
   logic        b_sel;
   logic        a_err, c_err, b_err;
   logic [3:0]  a_cnt;
   logic [15:0] c_cnt, b_cnt;

   mux_n_pipe_reg #(
      .WIDTH(32), .NUM_IN(3), .SEL_W(2), .RESET_VAL(32'hDEAD_BEEF), .CNT_W(4)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(din[95:0]), .sel(sel),
      .in_valid(in_valid), .en(en), .flush(flush), .err_clr(err_clr),
      .out_data(a_data), .out_valid(a_valid), .out_sel(a_sel),
      .sel_err(a_err), .cap_cnt(a_cnt)
   );

   mux_n_pipe_reg dut_c (
      .clk(clk), .rst_n(rst_n), .in_data(din), .sel(sel),
      .in_valid(in_valid), .en(en), .flush(flush), .err_clr(err_clr),
      .out_data(c_data), .out_valid(c_valid), .out_sel(c_sel),
      .sel_err(c_err), .cap_cnt(c_cnt)
   );

   mux_n_pipe_reg #(
      .WIDTH(5), .NUM_IN(2), .SEL_W(1), .RESET_VAL(5'd9), .CNT_W(16)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(din[9:0]), .sel(sel[0]),
      .in_valid(in_valid), .en(en), .flush(flush), .err_clr(err_clr),
      .out_data(b_data), .out_valid(b_valid), .out_sel(b_sel),
      .sel_err(b_err), .cap_cnt(b_cnt)
   );

   // Behavioural model, index 0=a, 1=c, 2=b
   int unsigned NIN  [3] = '{3, 4, 2};
   int unsigned W    [3] = '{32, 32, 5};
   int unsigned SW   [3] = '{2, 2, 1};
   int unsigned CMAX [3] = '{15, 65535, 65535};
   logic [31:0] RSTV [3] = '{32'hDEAD_BEEF, 32'h0, 32'd9};

   logic [31:0] m_data [3];
   logic        m_valid[3];
   logic [31:0] m_sel  [3];
   logic        m_err  [3];
   int unsigned m_cnt  [3];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            m_data[i]  <= RSTV[i];
            m_valid[i] <= 1'b0;
            m_sel[i]   <= 0;
            m_err[i]   <= 1'b0;
            m_cnt[i]   <= 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            int unsigned s, idx;
            logic [127:0] mask;
            logic in_range, capture;
            s        = 32'(sel) % (32'd1 << SW[i]);
            in_range = s < NIN[i];
            idx      = in_range ? s : 0;
            mask     = (128'h1 << W[i]) - 128'h1;
            capture  = !flush && en && in_valid;
            if (flush) begin
               m_data[i]  <= RSTV[i];
               m_valid[i] <= 1'b0;
               m_sel[i]   <= 0;
            end else if (en) begin
               m_data[i]  <= 32'((din >> (idx * W[i])) & mask);
               m_valid[i] <= in_valid;
               m_sel[i]   <= idx;
            end
            if (capture && !in_range) m_err[i] <= 1'b1;
            else if (err_clr)         m_err[i] <= 1'b0;
            if (capture && m_cnt[i] < CMAX[i]) m_cnt[i] <= m_cnt[i] + 1;
         end
      end
   end

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (rst_n && run_chk) begin
         chk("a_data",  a_data,          m_data[0]);
         chk("a_valid", 32'(a_valid),    32'(m_valid[0]));
         chk("a_sel",   32'(a_sel),      m_sel[0]);
         chk("a_err",   32'(a_err),      32'(m_err[0]));
         chk("a_cnt",   32'(a_cnt),      m_cnt[0]);
         chk("c_data",  c_data,          m_data[1]);
         chk("c_valid", 32'(c_valid),    32'(m_valid[1]));
         chk("c_sel",   32'(c_sel),      m_sel[1]);
         chk("c_err",   32'(c_err),      32'(m_err[1]));
         chk("c_cnt",   32'(c_cnt),      m_cnt[1]);
         chk("b_data",  32'(b_data),     m_data[2]);
         chk("b_valid", 32'(b_valid),    32'(m_valid[2]));
         chk("b_sel",   32'(b_sel),      m_sel[2]);
         chk("b_err",   32'(b_err),      32'(m_err[2]));
         chk("b_cnt",   32'(b_cnt),      m_cnt[2]);
      end
   end

   logic [127:0] PAT = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
   logic [31:0]  EXP_C [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

   initial begin
      din = '0; sel = '0; in_valid = 1'b0; en = 1'b0; flush = 1'b0; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_chk = 1'b1;
      chk("rst_a_data", a_data, 32'hDEAD_BEEF);
      chk("rst_b_data", 32'(b_data), 32'd9);

      // capture every input of the 4-way stage
      din = PAT; en = 1'b1; in_valid = 1'b1;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         @(negedge clk);
         chk("cap_c_data", c_data, EXP_C[s]);
         chk("cap_c_sel", 32'(c_sel), 32'(s));
      end
      chk("cap_c_cnt", 32'(c_cnt), 32'd4);
      chk("model_c_cnt", m_cnt[1], 32'd4);
      chk("cap_a_oob_err", 32'(a_err), 32'd1);

      // stall with moving inputs, then flush
      en = 1'b0;
      repeat (3) begin
         din = {$urandom, $urandom, $urandom, $urandom};
         sel = 2'($urandom);
         @(negedge clk);
         chk("stall_c_data", c_data, 32'h4444_4444);
      end
      flush = 1'b1; en = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_a_data", a_data, 32'hDEAD_BEEF);
      chk("flush_c_valid", 32'(c_valid), 32'd0);
      chk("flush_c_cnt", 32'(c_cnt), 32'd4);

      // out-of-range select on the 3-input stage
      din = PAT; en = 1'b0; err_clr = 1'b1;
      @(negedge clk);
      chk("oob_pre_clr", 32'(a_err), 32'd0);
      en = 1'b1; in_valid = 1'b1; sel = 2'b11; err_clr = 1'b0;
      @(negedge clk);
      chk("oob_a_data", a_data, 32'h1111_1111);
      chk("oob_a_sel", 32'(a_sel), 32'd0);
      chk("oob_a_err", 32'(a_err), 32'd1);
      chk("oob_c_sel", 32'(c_sel), 32'd3);
      err_clr = 1'b1;
      @(negedge clk);
      chk("oob_set_wins", 32'(a_err), 32'd1);
      en = 1'b0;
      @(negedge clk);
      err_clr = 1'b0;
      chk("oob_cleared", 32'(a_err), 32'd0);
      chk("oob_a_cnt", 32'(a_cnt), 32'd6);

      // saturation of the 4-bit counter
      en = 1'b1; in_valid = 1'b1;
      repeat (17) begin
         sel = 2'($urandom);
         @(negedge clk);
      end
      chk("sat_a_cnt", 32'(a_cnt), 32'd15);
      chk("model_sat", m_cnt[0], 32'd15);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("sat_hold", 32'(a_cnt), 32'd15);
      chk("inval_a_valid", 32'(a_valid), 32'd0);

      // 5-bit, 2-input stage
      din[9:0] = {5'd31, 5'd7}; in_valid = 1'b1; sel = 2'b01;
      @(negedge clk);
      chk("w5_sel1", 32'(b_data), 32'd31);
      sel = 2'b00;
      @(negedge clk);
      chk("w5_sel0", 32'(b_data), 32'd7);
      chk("w5_err", 32'(b_err), 32'd0);

      // asynchronous reset asserted mid-cycle
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_a_data", a_data, 32'hDEAD_BEEF);
      chk("arst_a_valid", 32'(a_valid), 32'd0);
      chk("arst_a_cnt", 32'(a_cnt), 32'd0);
      chk("arst_c_sel", 32'(c_sel), 32'd0);
      chk("arst_c_cnt", 32'(c_cnt), 32'd0);
      chk("arst_a_err", 32'(a_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         din      = {$urandom, $urandom, $urandom, $urandom};
         sel      = 2'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         en       = ($urandom_range(0, 4) != 0);
         flush    = ($urandom_range(0, 15) == 0);
         err_clr  = ($urandom_range(0, 7) == 0);
         @(negedge clk);
      end

      run_chk = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mux_n_pipe_reg.md
Name: mux_n_pipe_reg

Overview:
Parametrised N-input, WIDTH-bit selector whose output is registered as a stallable, flushable pipeline stage. It is the successor to the fixed 2/3/4-way 32-bit and 5-bit selectors. It is used at pipeline stage boundaries, for example forwarding-select into the ID/EX operand latch. It adds a valid bit, stall/flush control, out-of-range select detection and a saturating capture counter.

Parameters:
WIDTH, 32, data width of each input and the output
NUM_IN, 4, number of selectable inputs (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN
RESET_VAL, 32'h0000_0000, value loaded into out_data on reset and on flush (WIDTH bits)
CNT_W, 16, width of the capture counter

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  asynchronous, active-low reset
in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
sel  input  SEL_W  input select
in_valid  input  1  qualifies in_data/sel this cycle
en  input  1  stage advance; 0 = stall (hold)
flush  input  1  bubble insert; has priority over en
err_clr  input  1  clears sel_err
out_data  output  WIDTH  registered selected data
out_valid  output  1  registered valid
out_sel  output  SEL_W  registered select actually used
sel_err  output  1  sticky: a valid capture used sel >= NUM_IN
cap_cnt  output  CNT_W  count of valid captures, saturating

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately without a clock edge):
  - out_data=RESET_VAL, out_valid=0, out_sel=0, sel_err=0, cap_cnt=0.
- Latency: exactly 1 cycle from the sampled inputs to the outputs.
- Per rising edge, in priority order:
  1. flush=1:
     - out_data<=RESET_VAL, out_valid<=0, out_sel<=0.
     - cap_cnt and sel_err are unaffected by flush.
     - err_clr is still honoured.
  2. en=1 (capture):
     - out_data<=in_data[sel] when sel < NUM_IN; otherwise in_data[0] (input 0 slice).
     - out_sel<=sel when sel < NUM_IN; otherwise 0.
     - out_valid<=in_valid.
  3. en=0 (stall): all of out_data, out_valid and out_sel hold.
- Invalid capture: capture with in_valid=0 still loads out_data/out_sel (same as the fixed muxes). out_valid becomes 0 and the counter does not increment.
- sel_err:
  - Set on a capture with in_valid=1 and sel >= NUM_IN.
  - Cleared by err_clr=1.
  - If set and clear occur in the same cycle, set wins.
  - Holds otherwise.
- cap_cnt:
  - +1 on each capture with in_valid=1, including out-of-range selects.
  - Saturates at 2**CNT_W-1; no wrap.
- NUM_IN = 2**SEL_W: the out-of-range branch is unreachable; sel_err stays 0.
- No combinational path from any input to any output.
- sel containing X/Z is not a legal input; no required behaviour is defined for it.

Decomposition:
- Shared package mux_pkg holds:
  - default constants (WIDTH=32, REG_W=5 for register-index variants);
  - a function clog2 for callers to derive SEL_W.
- One natural sub-module: mux_n_sel. It is a purely combinational parametrised N-way selector (WIDTH, NUM_IN, SEL_W) that outputs the selected slice plus an oob flag. It is reusable standalone in place of the fixed muxes.
- mux_n_pipe_reg instantiates mux_n_sel and adds the stage register, error flag and counter.

Test Plan:
1. Reset check. Defaults, RESET_VAL=32'hDEAD_BEEF. Assert rst_n=0 mid-cycle -> out_data=32'hDEAD_BEEF, out_valid=0, out_sel=0, sel_err=0, cap_cnt=0 immediately, without waiting for clk.
2. Capture, all inputs. in_data inputs 0..3 = 32'h11111111, 22222222, 33333333, 44444444; en=1, in_valid=1; sel=0,1,2,3 on consecutive cycles -> out_data follows one cycle later, out_sel=0..3, cap_cnt=4.
3. Stall then flush. Stall (en=0) for 3 cycles while in_data and sel change -> outputs hold. Then flush=1 with en=1 -> out_valid=0, out_data=RESET_VAL, cap_cnt unchanged.
4. Out-of-range select. NUM_IN=3, SEL_W=2, sel=2'b11, in_valid=1, en=1 -> out_data=input 0 slice, out_sel=0, sel_err=1. Next cycle err_clr=1 together with another oob capture -> sel_err stays 1. Then err_clr alone -> sel_err=0.
5. Counter saturation. CNT_W=4: perform 17 valid captures -> cap_cnt reaches 15 and holds at 15. Captures with in_valid=0 -> no increment, out_valid=0.
6. Width generality. WIDTH=5, NUM_IN=2, SEL_W=1, inputs 5'd7 and 5'd31: sel=1 -> out_data=5'd31, sel=0 -> out_data=5'd7. sel_err never asserts.
